// File: rtl/mac_accumulator.sv
// Sums a programmed number of valid products into one dot-product result per vector; optional MAC_SAT_EN clamps on carry-out.
// Latency: result visible the cycle after the last accepted product (zero-length vectors one cycle after start).
// Backpressure: the result is held in DONE until out_ready; the product stream is never stalled.
module mac_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic               ovf_q, ovf_nxt;
  logic [LEN_W-1:0]   cnt, cnt_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic               out_valid_q;
  logic               busy_q;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic [ACC_W-1:0]   acc_add;

  assign sum   = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
  assign carry = sum[ACC_W];

`ifdef MAC_SAT_EN
  // Once the vector has overflowed, the clamp holds for the rest of it.
  assign acc_add = (carry || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf_q;
    cnt_nxt   = cnt;
    len_nxt   = len;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
          len_nxt   = vec_len;
          state_nxt = (vec_len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid) begin
          acc_nxt = acc_add;
          ovf_nxt = ovf_q | carry;
          cnt_nxt = cnt + LEN_ONE;
          if (cnt == (len - LEN_ONE)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      ovf_q       <= 1'b0;
      cnt         <= '0;
      len         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      ovf_q       <= ovf_nxt;
      cnt         <= cnt_nxt;
      len         <= len_nxt;
      out_valid_q <= (state_nxt == DONE);
      busy_q      <= (state_nxt != IDLE);
    end
  end

  assign acc_out   = acc;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator built with ACC_W=33 so the wrap/saturate cases are reachable.
module tb_mac_accumulator;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 33;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  int total = 0;
  int bad   = 0;

  mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec_len    (vec_len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_gap(input logic [PROD_W-1:0] p);
    prod_valid = 1'b1;
    prod       = p;
    tick();
    prod_valid = 1'b0;
    tick();
    tick();
  endtask

  logic [63:0] ovf_exp_acc;

  initial begin
`ifdef MAC_SAT_EN
    ovf_exp_acc = 64'h1_FFFF_FFFF;
`else
    ovf_exp_acc = 64'h0_FFFF_FFFD;
`endif
    rst = 1'b1; start = 1'b0; vec_len = '0; prod_valid = 1'b0; prod = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_ovf", ovf, 0);

    // 1: basic sum 1+2+3+4
    start = 1'b1; vec_len = 8'd4;
    tick();
    start = 1'b0;
    chk("t1_busy_accum", busy, 1);
    prod_valid = 1'b1;
    prod = 32'd1; tick();
    prod = 32'd2; tick();
    prod = 32'd3; tick();
    chk("t1_partial_acc", acc_out, 6);
    chk("t1_not_done", out_valid, 0);
    prod = 32'd4; tick();
    prod_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_acc", acc_out, 10);
    chk("t1_ovf", ovf, 0);
    chk("t1_busy_done", busy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_hs_valid", out_valid, 0);
    chk("t1_hs_busy", busy, 0);
    chk("t1_hs_acc_kept", acc_out, 10);

    // 2: products separated by idle gaps
    start = 1'b1; vec_len = 8'd3;
    tick();
    start = 1'b0;
    send_gap(32'hFFFF_FFFF);
    chk("t2_acc_after_p1", acc_out, 64'hFFFF_FFFF);
    chk("t2_no_valid_gap", out_valid, 0);
    send_gap(32'd5);
    chk("t2_acc_after_p2", acc_out, 64'h1_0000_0004);
    send_gap(32'd7);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_acc", acc_out, 64'h1_0000_000B);
    chk("t2_ovf", ovf, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 3: zero-length vector, stray prod_valid in IDLE and DONE
    prod_valid = 1'b1; prod = 32'd99;
    tick();
    chk("t3_idle_ignore", acc_out, 64'h1_0000_000B);
    start = 1'b1; vec_len = 8'd0;
    tick();
    start = 1'b0;
    chk("t3_out_valid", out_valid, 1);
    chk("t3_acc_zero", acc_out, 0);
    tick();
    chk("t3_done_ignore", acc_out, 0);
    prod_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_hs_valid", out_valid, 0);

    // 4: backpressure with stray start/prod during stall
    start = 1'b1; vec_len = 8'd2;
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 32'd6; tick();
    prod = 32'd9; tick();
    for (int i = 0; i < 5; i++) begin
      prod_valid = 1'b1; prod = 32'd100; start = 1'b1; vec_len = 8'd5;
      chk($sformatf("t4_stall_valid_%0d", i), out_valid, 1);
      chk($sformatf("t4_stall_acc_%0d", i), acc_out, 15);
      tick();
    end
    prod_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("t4_hs_valid", out_valid, 0);
    chk("t4_start_dropped", busy, 0);
    chk("t4_acc_kept", acc_out, 15);

    // 5: overflow past 33 bits
    start = 1'b1; vec_len = 8'd3;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("t5_no_ovf_yet", ovf, 0);
    tick();
    prod_valid = 1'b0;
    chk("t5_out_valid", out_valid, 1);
    chk("t5_acc", acc_out, ovf_exp_acc);
    chk("t5_ovf", ovf, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_ovf_kept", ovf, 1);

    // 6: reset mid-vector, then a fresh single-product vector
    start = 1'b1; vec_len = 8'd4;
    tick();
    start = 1'b0;
    chk("t6_start_clears_ovf", ovf, 0);
    prod_valid = 1'b1; prod = 32'd8;
    tick();
    tick();
    prod_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_acc", acc_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ovf", ovf, 0);
    tick();
    chk("t6_no_result", out_valid, 0);
    start = 1'b1; vec_len = 8'd1;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'd42;
    tick();
    prod_valid = 1'b0;
    chk("t6_out_valid", out_valid, 1);
    chk("t6_acc", acc_out, 42);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_hs_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
